// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch controller.
// Holds the FSM state encoding, the opcode field position and the set of
// opcodes that carry a trailing immediate word.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_VEC_WAIT = 2'd0,
        S_VEC_LOAD = 2'd1,
        S_RUN      = 2'd2
    } state_t;

    // Opcode occupies the top OPC_W bits of the instruction word.
    localparam int OPC_W = 5;

    // Two-word opcodes: instruction word followed by a 16-bit immediate.
    localparam logic [OPC_W-1:0] OP_LDM  = 5'h14;
    localparam logic [OPC_W-1:0] OP_IADD = 5'h15;
    localparam logic [OPC_W-1:0] OP_LDD  = 5'h16;
    localparam logic [OPC_W-1:0] OP_STD  = 5'h17;

endpackage

// File: rtl/fetch_controller_len_decode.sv
// fetch_len_decode: instruction length decoder.
// Flags instructions that are followed by an immediate word.
// Ports:
//   instr     in  Num_of_bits  instruction word
//   two_word  out 1            instruction carries an immediate
module fetch_len_decode
    import fetch_pkg::*;
#(
    parameter int Num_of_bits = 16
) (
    input  logic [Num_of_bits-1:0] instr,
    output logic                   two_word
);

    logic [OPC_W-1:0] opcode;
    logic             unused_low;

    assign opcode     = instr[Num_of_bits-1 -: OPC_W];
    assign unused_low = ^instr[Num_of_bits-OPC_W-1:0];

    always_comb begin
        two_word = 1'b0;
        unique case (opcode)
            OP_LDM, OP_IADD, OP_LDD, OP_STD: two_word = 1'b1;
            default:                         two_word = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: owns the PC and sequences the synchronous instruction
// memory for the 5-stage pipeline (reset-vector load, 1/2-word advance,
// stall hold, branch redirect).
// Optional feature macro: FETCH_PERF_EN adds saturating perf counters.
// Ports:
//   clk, rst (async, active-high)
//   stall, branch_taken, branch_target      pipeline control
//   imem_instr, imem_imm                    mem[pc_reg], mem[pc_reg+1]
//   imem_pc                                 memory read address (= pc_next)
//   fetch_valid/pc/instr/imm/two_word       to IF/ID register
//   perf_fetched, perf_stalled              only with FETCH_PERF_EN
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int                  Num_of_bits = 16,
    parameter int                  pc_width    = 32,
    parameter logic [pc_width-1:0] RESET_VEC   = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [pc_width-1:0]    branch_target,
    input  logic [Num_of_bits-1:0] imem_instr,
    input  logic [Num_of_bits-1:0] imem_imm,
    output logic [pc_width-1:0]    imem_pc,
    output logic                   fetch_valid,
    output logic [pc_width-1:0]    fetch_pc,
    output logic [Num_of_bits-1:0] fetch_instr,
    output logic [Num_of_bits-1:0] fetch_imm,
`ifdef FETCH_PERF_EN
    output logic [31:0]            perf_fetched,
    output logic [31:0]            perf_stalled,
`endif
    output logic                   fetch_two_word
);

    localparam int                  CAT_W  = 2 * Num_of_bits;
    localparam logic [pc_width-1:0] PC_ONE = pc_width'(1);
    localparam logic [pc_width-1:0] PC_TWO = pc_width'(2);

    state_t              state, state_next;
    logic [pc_width-1:0] pc_reg, pc_next, start_pc;
    logic [CAT_W-1:0]    vec_word;
    logic                two_word;

    fetch_len_decode #(.Num_of_bits(Num_of_bits)) u_len_decode (
        .instr    (imem_instr),
        .two_word (two_word)
    );

    // mem[RESET_VEC] is the high half of the start PC.
    assign vec_word = {imem_instr, imem_imm};

    generate
        if (pc_width > CAT_W) begin : g_zext
            assign start_pc = {{(pc_width-CAT_W){1'b0}}, vec_word};
        end else if (pc_width == CAT_W) begin : g_same
            assign start_pc = vec_word;
        end else begin : g_trunc
            logic [CAT_W-pc_width-1:0] unused_hi;
            assign unused_hi = vec_word[CAT_W-1:pc_width];
            assign start_pc  = vec_word[pc_width-1:0];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_VEC_WAIT;
            pc_reg <= RESET_VEC;
        end else begin
            state  <= state_next;
            pc_reg <= pc_next;
        end
    end

    always_comb begin
        state_next  = state;
        pc_next     = pc_reg;
        fetch_valid = 1'b0;
        unique case (state)
            S_VEC_WAIT: begin
                pc_next    = RESET_VEC;
                state_next = S_VEC_LOAD;
            end
            S_VEC_LOAD: begin
                pc_next    = start_pc;
                state_next = S_RUN;
            end
            S_RUN: begin
                if (branch_taken) begin
                    // Word presented this cycle is wrong-path: squash it.
                    pc_next = branch_target;
                end else if (stall) begin
                    fetch_valid = 1'b1;
                    pc_next     = pc_reg;
                end else begin
                    fetch_valid = 1'b1;
                    pc_next     = pc_reg + (two_word ? PC_TWO : PC_ONE);
                end
            end
            default: begin
                pc_next    = RESET_VEC;
                state_next = S_VEC_WAIT;
            end
        endcase
    end

    assign imem_pc        = pc_next;
    assign fetch_pc       = pc_reg;
    assign fetch_instr    = imem_instr;
    assign fetch_imm      = imem_imm;
    assign fetch_two_word = two_word;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stalled <= '0;
        end else begin
            if (fetch_valid && !stall && (perf_fetched != '1))
                perf_fetched <= perf_fetched + 32'd1;
            if ((state == S_RUN) && stall && !branch_taken && (perf_stalled != '1))
                perf_stalled <= perf_stalled + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [15:0] imem_instr;
    logic [15:0] imem_imm;
    logic [31:0] imem_pc;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [15:0] fetch_instr;
    logic [15:0] fetch_imm;
    logic        fetch_two_word;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stalled;
`endif

    int errors = 0;
    int checks = 0;

    // Synchronous memory model: address registered at posedge.
    logic [15:0] mem [256];
    logic [31:0] raddr;
    logic [31:0] raddr_p1;

    always @(posedge clk) raddr <= imem_pc;
    assign raddr_p1   = raddr + 32'd1;
    assign imem_instr = mem[raddr[7:0]];
    assign imem_imm   = mem[raddr_p1[7:0]];

    fetch_controller dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_instr     (imem_instr),
        .imem_imm       (imem_imm),
        .imem_pc        (imem_pc),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .fetch_instr    (fetch_instr),
        .fetch_imm      (fetch_imm),
`ifdef FETCH_PERF_EN
        .perf_fetched   (perf_fetched),
        .perf_stalled   (perf_stalled),
`endif
        .fetch_two_word (fetch_two_word)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fetch(input string name, input logic [31:0] pc,
                             input logic [15:0] instr);
        checks++;
        if (fetch_valid !== 1'b1 || fetch_pc !== pc || fetch_instr !== instr) begin
            errors++;
            $display("FAIL %s: valid=%b pc=%h instr=%h, expected valid=1 pc=%h instr=%h",
                     name, fetch_valid, fetch_pc, fetch_instr, pc, instr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        step(); step();
        checks++;
        if (fetch_valid !== 1'b0 || imem_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_hold: valid=%b imem_pc=%h, expected 0/0", fetch_valid, imem_pc);
        end
        rst = 1'b0;
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h77;   // ignored before S_RUN
        #1;
        checks++;
        if (fetch_valid !== 1'b0 || imem_pc !== 32'h0) begin
            errors++;
            $display("FAIL vec_wait: valid=%b imem_pc=%h, expected 0/0", fetch_valid, imem_pc);
        end
        step();
        checks++;
        if (fetch_valid !== 1'b0 || imem_pc !== 32'h10) begin
            errors++;
            $display("FAIL vec_load: valid=%b imem_pc=%h, expected 0/00000010", fetch_valid, imem_pc);
        end
        stall = 1'b0; branch_taken = 1'b0;
        step();
        chk_fetch("first_fetch", 32'h10, 16'h0801);
    endtask

    task automatic test_sequential();
        checks++;
        if (imem_pc !== 32'h11) begin
            errors++;
            $display("FAIL lead_0x10: imem_pc=%h, expected 00000011", imem_pc);
        end
        step();
        chk_fetch("seq_0x11", 32'h11, 16'h1002);
        checks++;
        if (fetch_two_word !== 1'b0 || imem_pc !== 32'h12) begin
            errors++;
            $display("FAIL one_word_0x11: two_word=%b imem_pc=%h, expected 0/00000012",
                     fetch_two_word, imem_pc);
        end
    endtask

    task automatic test_two_word();
        step();
        chk_fetch("ldm_0x12", 32'h12, 16'hA000);
        checks++;
        if (fetch_two_word !== 1'b1 || fetch_imm !== 16'hBEEF || imem_pc !== 32'h14) begin
            errors++;
            $display("FAIL ldm_imm: two_word=%b imm=%h imem_pc=%h, expected 1/beef/00000014",
                     fetch_two_word, fetch_imm, imem_pc);
        end
        step();
        chk_fetch("after_ldm", 32'h14, 16'h0803);
    endtask

    task automatic test_stall();
        stall = 1'b1;
        #1;
        checks++;
        if (imem_pc !== 32'h14 || fetch_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_addr: imem_pc=%h valid=%b, expected 00000014/1", imem_pc, fetch_valid);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            chk_fetch("stall_hold", 32'h14, 16'h0803);
        end
        stall = 1'b0;
        step();
        chk_fetch("stall_release", 32'h15, 16'h0804);
    endtask

    task automatic test_redirect_with_stall();
        branch_taken = 1'b1; branch_target = 32'h40; stall = 1'b1;
        #1;
        checks++;
        if (fetch_valid !== 1'b0 || imem_pc !== 32'h40) begin
            errors++;
            $display("FAIL squash: valid=%b imem_pc=%h, expected 0/00000040", fetch_valid, imem_pc);
        end
        step();
        branch_taken = 1'b0; stall = 1'b0;
        #1;
        chk_fetch("redirect_0x40", 32'h40, 16'h0805);
    endtask

    task automatic test_wrap();
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
        step();
        branch_taken = 1'b0;
        #1;
        chk_fetch("wrap_last", 32'hFFFF_FFFF, 16'hA800);
        checks++;
        if (fetch_two_word !== 1'b1 || fetch_imm !== 16'h0000 || imem_pc !== 32'h1) begin
            errors++;
            $display("FAIL wrap_imm: two_word=%b imm=%h imem_pc=%h, expected 1/0000/00000001",
                     fetch_two_word, fetch_imm, imem_pc);
        end
        step();
        chk_fetch("wrap_next", 32'h1, 16'h0010);
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (fetch_valid !== 1'b0 || imem_pc !== 32'h0) begin
            errors++;
            $display("FAIL async_rst: valid=%b imem_pc=%h, expected 0/00000000", fetch_valid, imem_pc);
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if (fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL rerun_load: valid=%b, expected 0", fetch_valid);
        end
        step();
        chk_fetch("rerun_first", 32'h10, 16'h0801);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h00] = 16'h0000;
        mem[8'h01] = 16'h0010;
        mem[8'h10] = 16'h0801;
        mem[8'h11] = 16'h1002;
        mem[8'h12] = 16'hA000;   // LDM
        mem[8'h13] = 16'hBEEF;
        mem[8'h14] = 16'h0803;
        mem[8'h15] = 16'h0804;
        mem[8'h40] = 16'h0805;
        mem[8'hFF] = 16'hA800;   // IADD at last address
        test_reset();
        test_sequential();
        test_two_word();
        test_stall();
        test_redirect_with_stall();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
